// File: rtl/metronomo_controle.sv
// Metronome sequencer: drives the metronome's clear/enable/tempo controls,
// converts its beat and half-beat levels into single-cycle events, and runs
// a round of N_BATIDAS beats with start/pause/resume/stop and measure tracking.
module metronomo_controle #(
  parameter int BATIDAS_COMPASSO = 4,
  parameter int N_BATIDAS        = 16,
  parameter int W                = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         pausar,
  input  logic         parar,
  input  logic         modo_120,
  input  logic         metro,
  input  logic         meio_metro,
  output logic         zeraMetro,
  output logic         contaMetro,
  output logic         metro_120BPM,
  output logic         batida,
  output logic         meia_batida,
  output logic         compasso,
  output logic [W-1:0] contagem,
  output logic         fim_rodada,
  output logic [2:0]   db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    CONTA   = 3'd2,
    PAUSA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam int            PW      = $clog2(BATIDAS_COMPASSO);
  localparam logic [W-1:0]  N_MAX   = W'(N_BATIDAS);
  localparam logic [W-1:0]  N_ULT   = W'(N_BATIDAS - 1);
  localparam logic [PW-1:0] POS_MAX = PW'(BATIDAS_COMPASSO - 1);

  estado_t       estado;
  logic [PW-1:0] posicao;
  logic          metro_q;
  logic          meio_q;
  logic          sobe_metro;
  logic          sobe_meio;

  // Rising edges only matter while counting; anything outside CONTA is dropped.
  assign sobe_metro = metro      & ~metro_q & (estado == CONTA);
  assign sobe_meio  = meio_metro & ~meio_q  & (estado == CONTA);

  // Moore controls to the metronome and state-derived status.
  assign zeraMetro  = (estado == OCIOSO) || (estado == PREPARA) || (estado == FIM);
  assign contaMetro = (estado == CONTA);
  assign fim_rodada = (estado == FIM);
  assign db_estado  = estado;

  // Round sequencer, beat/half-beat event generation and beat bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      contagem     <= '0;
      posicao      <= '0;
      metro_120BPM <= 1'b0;
      metro_q      <= 1'b0;
      meio_q       <= 1'b0;
      batida       <= 1'b0;
      meia_batida  <= 1'b0;
      compasso     <= 1'b0;
    end else begin
      batida      <= 1'b0;
      meia_batida <= 1'b0;
      compasso    <= 1'b0;
      metro_q     <= metro;
      meio_q      <= meio_metro;
      case (estado)
        OCIOSO: begin
          contagem <= '0;
          if (iniciar) begin
            estado       <= PREPARA;
            metro_120BPM <= modo_120;
          end
        end
        PREPARA: begin
          contagem <= '0;
          posicao  <= '0;
          metro_q  <= 1'b0;
          meio_q   <= 1'b0;
          estado   <= CONTA;
        end
        CONTA: begin
          // parar discards a coincident beat; pausar still lets it count.
          if (parar) begin
            estado   <= OCIOSO;
            contagem <= '0;
          end else begin
            if (sobe_meio) meia_batida <= 1'b1;
            if (sobe_metro) begin
              batida <= 1'b1;
              if (contagem != N_MAX) contagem <= contagem + 1'b1;
              if (posicao == POS_MAX) begin
                posicao  <= '0;
                compasso <= 1'b1;
              end else begin
                posicao <= posicao + 1'b1;
              end
            end
            if (sobe_metro && (contagem == N_ULT)) estado <= FIM;
            else if (pausar)                      estado <= PAUSA;
          end
        end
        PAUSA: begin
          if (parar) begin
            estado   <= OCIOSO;
            contagem <= '0;
          end else if (iniciar) begin
            estado <= CONTA;
          end
        end
        FIM: begin
          if (parar) begin
            estado   <= OCIOSO;
            contagem <= '0;
          end else if (iniciar) begin
            estado       <= PREPARA;
            metro_120BPM <= modo_120;
          end
        end
        default: begin
          estado   <= OCIOSO;
          contagem <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_metronomo_controle.sv
// Bench for metronomo_controle: directed scenarios plus randomized traffic,
// checked against a behavioural model of the round/beat rules.
module tb_metronomo_controle;

  localparam int B = 4;
  localparam int N = 16;
  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         iniciar = 1'b0, pausar = 1'b0, parar = 1'b0, modo_120 = 1'b0;
  logic         metro = 1'b0, meio_metro = 1'b0;
  logic         zeraMetro, contaMetro, metro_120BPM, batida, meia_batida, compasso;
  logic [W-1:0] contagem;
  logic         fim_rodada;
  logic [2:0]   db_estado;

  int checks   = 0;
  int failures = 0;

  metronomo_controle #(.BATIDAS_COMPASSO(B), .N_BATIDAS(N), .W(W)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .parar(parar),
    .modo_120(modo_120), .metro(metro), .meio_metro(meio_metro),
    .zeraMetro(zeraMetro), .contaMetro(contaMetro), .metro_120BPM(metro_120BPM),
    .batida(batida), .meia_batida(meia_batida), .compasso(compasso),
    .contagem(contagem), .fim_rodada(fim_rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural reference: phase number, beat count and measure derived from count.
  int m_st  = 0;
  int m_cnt = 0;
  bit m_pm = 0, m_ph = 0, m_bpm = 0, m_bat = 0, m_meia = 0, m_comp = 0;

  always @(posedge clock) begin : model
    bit beat, half;
    int prev_st;
    prev_st = m_st;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_pm = 0; m_ph = 0; m_bpm = 0;
      m_bat = 0; m_meia = 0; m_comp = 0;
    end else begin
      beat   = (m_st == 2) && metro && !m_pm && !parar;
      half   = (m_st == 2) && meio_metro && !m_ph && !parar;
      m_bat  = beat;
      m_meia = half;
      m_comp = 0;
      if (beat) begin
        m_cnt  = (m_cnt < N) ? m_cnt + 1 : N;
        m_comp = (m_cnt % B) == 0;
      end
      if (m_st == 1) begin
        m_cnt = 0; m_st = 2;
      end else if (m_st != 0 && parar) begin
        m_st = 0; m_cnt = 0;
      end else if (m_st == 2) begin
        if (beat && m_cnt == N) m_st = 4;
        else if (pausar)        m_st = 3;
      end else if (m_st == 3) begin
        if (iniciar) m_st = 2;
      end else if (iniciar) begin
        m_st = 1; m_bpm = modo_120;
      end
      m_pm = (prev_st == 1) ? 1'b0 : metro;
      m_ph = (prev_st == 1) ? 1'b0 : meio_metro;
    end
  end

  logic [14:0] dut_vec, mdl_vec;
  assign dut_vec = {db_estado, zeraMetro, contaMetro, metro_120BPM, batida, meia_batida,
                    compasso, fim_rodada, contagem};
  always_comb begin
    mdl_vec = {3'(m_st), (m_st == 0 || m_st == 1 || m_st == 4), (m_st == 2), m_bpm,
               m_bat, m_meia, m_comp, (m_st == 4), W'(m_cnt)};
  end

  // Stimulus-only helpers.
  task automatic do_reset();
    reset = 1; iniciar = 0; pausar = 0; parar = 0; metro = 0; meio_metro = 0;
    @(negedge clock); @(negedge clock);
    reset = 0;
  endtask

  task automatic start_round(input bit modo);
    modo_120 = modo; iniciar = 1;
    @(negedge clock);
    iniciar = 0;
    @(negedge clock);
  endtask

  task automatic bater(input int n);
    for (int i = 0; i < n; i++) begin
      metro = 1; repeat (2) @(negedge clock);
      metro = 0; repeat (2) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    @(negedge clock); @(negedge clock);
    checks++;
    if ({db_estado, zeraMetro, contaMetro, contagem} !== {3'd0, 1'b1, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {db_estado, zeraMetro, contaMetro, contagem},
               {3'd0, 1'b1, 1'b0, 5'd0});
    end
    checks++;
    if ({batida, meia_batida, compasso, metro_120BPM, fim_rodada} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=00000",
               {batida, meia_batida, compasso, metro_120BPM, fim_rodada});
    end
    checks++;
    if (dut_vec !== mdl_vec) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec, mdl_vec);
    end
    reset = 0;
  endtask

  task automatic test_round();
    int nb, nc, bad;
    nb = 0; nc = 0; bad = 0;
    start_round(1'b1);
    for (int b = 0; b < N; b++) begin
      for (int ph = 0; ph < 2; ph++) begin
        metro = (ph == 0);
        repeat ($urandom_range(1, 3)) begin
          meio_metro = 1'($urandom_range(0, 1));
          @(negedge clock);
          checks++;
          if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL round_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec);
          end
          if (batida) begin
            nb++;
            if (int'(contagem) != nb || compasso != ((nb % B) == 0)) bad++;
          end
          if (compasso) nc++;
        end
      end
    end
    meio_metro = 0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL round_beat_seq got=%0d exp=0 bad beats", bad);
    end
    checks++;
    if (nb != N || nc != N / B) begin
      failures++;
      $display("FAIL round_pulse_counts got=%0d/%0d exp=%0d/%0d", nb, nc, N, N / B);
    end
    checks++;
    if ({db_estado, fim_rodada, metro_120BPM, contagem} !== {3'd4, 1'b1, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL round_end got=%h exp=%h", {db_estado, fim_rodada, metro_120BPM, contagem},
               {3'd4, 1'b1, 1'b1, 5'd16});
    end
  endtask

  task automatic test_pause();
    int nb;
    nb = 0;
    do_reset();
    start_round(1'b0);
    bater(5);
    pausar = 1; @(negedge clock); pausar = 0;
    checks++;
    if ({db_estado, contaMetro, contagem} !== {3'd3, 1'b0, 5'd5}) begin
      failures++;
      $display("FAIL pause_hold got=%h exp=%h", {db_estado, contaMetro, contagem},
               {3'd3, 1'b0, 5'd5});
    end
    metro = 1;
    repeat (2) begin @(negedge clock); nb += batida; end
    metro = 0;
    @(negedge clock); nb += batida;
    checks++;
    if (nb != 0 || contagem !== 5'd5) begin
      failures++;
      $display("FAIL pause_edge got=%0d/%0d exp=0/5", nb, contagem);
    end
    iniciar = 1; @(negedge clock); iniciar = 0;
    checks++;
    if (db_estado !== 3'd2) begin
      failures++;
      $display("FAIL pause_resume got=%0d exp=2", db_estado);
    end
    metro = 1; @(negedge clock);
    checks++;
    if ({batida, contagem} !== {1'b1, 5'd6}) begin
      failures++;
      $display("FAIL pause_next_beat got=%h exp=%h", {batida, contagem}, {1'b1, 5'd6});
    end
    metro = 0; @(negedge clock);
    checks++;
    if (dut_vec !== mdl_vec) begin
      failures++;
      $display("FAIL pause_model got=%h exp=%h", dut_vec, mdl_vec);
    end
  endtask

  task automatic test_parar_beat();
    do_reset();
    start_round(1'b0);
    bater(3);
    metro = 1; parar = 1; @(negedge clock); parar = 0;
    checks++;
    if ({batida, db_estado, contagem} !== {1'b0, 3'd0, 5'd0}) begin
      failures++;
      $display("FAIL parar_beat got=%h exp=%h", {batida, db_estado, contagem}, 9'd0);
    end
    @(negedge clock); metro = 0;
    checks++;
    if (batida !== 1'b0 || dut_vec !== mdl_vec) begin
      failures++;
      $display("FAIL parar_after got=%h exp=%h", dut_vec, mdl_vec);
    end
  endtask

  task automatic test_pause_beat();
    do_reset();
    start_round(1'b0);
    bater(7);
    metro = 1; pausar = 1; @(negedge clock); pausar = 0;
    checks++;
    if ({batida, compasso, db_estado, contagem} !== {1'b1, 1'b1, 3'd3, 5'd8}) begin
      failures++;
      $display("FAIL pause_beat got=%h exp=%h", {batida, compasso, db_estado, contagem},
               {1'b1, 1'b1, 3'd3, 5'd8});
    end
    metro = 0; @(negedge clock);
  endtask

  task automatic test_hold();
    int nb;
    nb = 0;
    do_reset();
    start_round(1'b1);
    metro = 1;
    repeat (10) begin @(negedge clock); nb += batida; end
    checks++;
    if (nb != 1 || contagem !== 5'd1) begin
      failures++;
      $display("FAIL hold_one_beat got=%0d/%0d exp=1/1", nb, contagem);
    end
    metro = 0; @(negedge clock);
    metro = 1; @(negedge clock);
    reset = 1; @(negedge clock);
    checks++;
    if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL reset_mid_conta got=%h exp=%h", dut_vec, 15'h0800);
    end
    reset = 0; metro = 0; @(negedge clock);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      iniciar  = ($urandom_range(0, 7) == 0);
      pausar   = ($urandom_range(0, 9) == 0);
      parar    = ($urandom_range(0, 39) == 0);
      modo_120 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) metro = ~metro;
      if ($urandom_range(0, 1) == 0) meio_metro = ~meio_metro;
      @(negedge clock);
      checks++;
      if (dut_vec !== mdl_vec) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
      end
    end
    iniciar = 0; pausar = 0; parar = 0;
  endtask

  initial begin
    test_reset();
    test_round();
    test_pause();
    test_parar_beat();
    test_pause_beat();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
